// File: rtl/bank_htu_set_entry_wb_pkg.sv
// Shared definitions for the bank HTU set entry: request op codes,
// per-sector state encodings and the writeback FSM state enum.
package bank_htu_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_FLUSH = 2'd2,
        OP_INVAL = 2'd3
    } op_e;

    // Encoding 2'd3 is never written into the array.
    typedef enum logic [1:0] {
        SEC_INVALID = 2'd0,
        SEC_CLEAN   = 2'd1,
        SEC_DIRTY   = 2'd2
    } sec_state_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WB_WAIT = 1'b1
    } fsm_e;

endpackage

// File: rtl/bank_htu_set_entry_wb_if.sv
// Bus bundle between the bank pipeline (master) and one set entry (slave).
// Carries the request handshake, the registered response, the dirty-victim
// writeback port and the valid-line count.
interface bank_htu_set_entry_wb_if #(
    parameter int WAYS    = 8,
    parameter int SECTORS = 2,
    parameter int TAG_W   = 22
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SEC_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;

    logic               req_valid_i;
    logic               req_ready_o;
    logic [1:0]         req_op_i;
    logic [TAG_W-1:0]   req_tag_i;
    logic [SEC_W-1:0]   req_sector_i;
    logic               rsp_valid_o;
    logic               rsp_hit_o;
    logic [WAY_W-1:0]   rsp_way_o;
    logic [1:0]         rsp_state_o;
    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [TAG_W-1:0]   wb_tag_o;
    logic [WAY_W-1:0]   wb_way_o;
    logic [SECTORS-1:0] wb_mask_o;
    logic [WAY_W:0]     valid_count_o;

    modport master (
        output req_valid_i, req_op_i, req_tag_i, req_sector_i, wb_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_state_o,
               wb_valid_o, wb_tag_o, wb_way_o, wb_mask_o, valid_count_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_tag_i, req_sector_i, wb_ready_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_state_o,
               wb_valid_o, wb_tag_o, wb_way_o, wb_mask_o, valid_count_o
    );

endinterface

// File: rtl/bank_htu_set_entry_wb_chk.sv
// Simulation-only checker: an accepted request may hit at most one way.
// Ports: clk_i, rst_i, check_i (request accepted), hit_vec_i (per-way hit).
module bank_htu_set_entry_wb_chk #(
    parameter int WAYS = 8
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            check_i,
    input logic [WAYS-1:0] hit_vec_i
);

    a_single_hit: assert property (@(posedge clk_i) disable iff (rst_i)
        check_i |-> $onehot0(hit_vec_i))
        else $error("set entry: more than one way hit the same tag");

endmodule

// File: rtl/bank_htu_set_entry_wb_plru.sv
// Tree-PLRU for one set. Owns WAYS-1 node bits in heap order (root = 0,
// children of n at 2n+1 / 2n+2). A node bit of 0 steers the victim to the
// lower half. A touch points every node on the way's path away from it.
// Ports: clk_i, rst_i (sync, active-high), touch_valid_i, touch_way_i,
//        victim_oh_o (one-hot victim way, combinational from the register).
module bank_htu_plru_tree_param #(
    parameter int  WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             touch_valid_i,
    input  logic [WAY_W-1:0] touch_way_i,
    output logic [WAYS-1:0]  victim_oh_o
);

    logic [WAYS-2:0]  node_r;
    logic [WAYS-2:0]  node_nxt_s;
    logic [WAY_W-1:0] vic_way_s;

    // Walk the tree for the victim and compute the post-touch node bits.
    always_comb begin
        int vi;
        int ti;
        logic vd;
        logic td;
        node_nxt_s = node_r;
        vic_way_s  = '0;
        vi         = 0;
        ti         = 0;
        for (int l = 0; l < WAY_W; l++) begin
            vd                      = node_r[vi];
            vic_way_s[WAY_W-1-l]    = vd;
            vi                      = 2 * vi + 1 + int'(vd);
            td                      = touch_way_i[WAY_W-1-l];
            if (touch_valid_i) begin
                node_nxt_s[ti] = ~td;
            end else begin
                node_nxt_s[ti] = node_r[ti];
            end
            ti                      = 2 * ti + 1 + int'(td);
        end
    end

    // Decode the victim way to one-hot.
    always_comb begin
        victim_oh_o            = '0;
        victim_oh_o[vic_way_s] = 1'b1;
    end

    // Node register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            node_r <= '0;
        end else begin
            node_r <= node_nxt_s;
        end
    end

endmodule

// File: rtl/bank_htu_set_entry_wb.sv
// Hit-tracking set entry for one cache set: WAYS lines of tag + per-sector
// state, invalid-first / tree-PLRU victim selection, registered response and
// a dirty-victim writeback port with back-pressure.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of
//        bank_htu_set_entry_wb_if: request, response, writeback, count).
module bank_htu_set_entry_wb
    import bank_htu_pkg::*;
#(
    parameter int  WAYS    = 8,
    parameter int  SECTORS = 2,
    parameter int  TAG_W   = 22,
    localparam int WAY_W   = $clog2(WAYS)
) (
    input logic                     clk_i,
    input logic                     rst_i,
    bank_htu_set_entry_wb_if.slave  bus
);

    typedef logic [SECTORS-1:0][1:0] line_t;

    logic [TAG_W-1:0]   tag_r  [WAYS];
    line_t              line_r [WAYS];
    fsm_e               state_r, state_nxt_s;
    logic               rsp_valid_r, rsp_hit_r;
    logic [WAY_W-1:0]   rsp_way_r, wb_way_r;
    logic [1:0]         rsp_state_r;
    logic [TAG_W-1:0]   wb_tag_r;
    logic [SECTORS-1:0] wb_mask_r;
    logic [WAY_W:0]     count_r;

    logic [WAYS-1:0]    line_valid_s, hit_vec_s, plru_oh_s;
    logic               accept_s, hit_s, rw_s, have_inv_s;
    logic [WAY_W-1:0]   hit_way_s, victim_way_s, touch_way_s, upd_way_s;
    logic [TAG_W-1:0]   upd_tag_s, wb_tag_nxt_s;
    line_t              upd_line_s;
    logic [SECTORS-1:0] wb_mask_nxt_s;
    logic               wb_gen_s, cnt_inc_s, cnt_dec_s;
    logic [WAY_W-1:0]   rsp_way_nxt_s;
    logic [1:0]         rsp_state_nxt_s;

    // Lowest set index of a way vector.
    function automatic logic [WAY_W-1:0] first_set(input logic [WAYS-1:0] vec);
        logic [WAY_W-1:0] idx;
        idx = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            idx = vec[w] ? WAY_W'(w) : idx;
        end
        return idx;
    endfunction

    // Sectors of a line that hold a given state.
    function automatic logic [SECTORS-1:0] sec_match(input line_t line, input logic [1:0] st);
        logic [SECTORS-1:0] m;
        for (int s = 0; s < SECTORS; s++) begin
            m[s] = (line[s] == st);
        end
        return m;
    endfunction

    // Tag lookup, victim choice and handshake.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            line_valid_s[w] = ~&sec_match(line_r[w], SEC_INVALID);
            hit_vec_s[w]    = line_valid_s[w] && (tag_r[w] == bus.req_tag_i);
        end
        accept_s     = bus.req_valid_i && (state_r == ST_IDLE);
        hit_s        = |hit_vec_s;
        hit_way_s    = first_set(hit_vec_s);
        have_inv_s   = ~&line_valid_s;
        victim_way_s = have_inv_s ? first_set(~line_valid_s) : first_set(plru_oh_s);
        rw_s         = (bus.req_op_i == OP_READ) || (bus.req_op_i == OP_WRITE);
        touch_way_s  = hit_s ? hit_way_s : victim_way_s;
    end

    // Next line contents, writeback payload and response for this request.
    always_comb begin
        upd_way_s       = hit_way_s;
        upd_tag_s       = tag_r[hit_way_s];
        upd_line_s      = line_r[hit_way_s];
        wb_gen_s        = 1'b0;
        wb_tag_nxt_s    = tag_r[hit_way_s];
        wb_mask_nxt_s   = '0;
        cnt_inc_s       = 1'b0;
        cnt_dec_s       = 1'b0;
        rsp_way_nxt_s   = '0;
        rsp_state_nxt_s = SEC_INVALID;
        if (hit_s) begin
            case (op_e'(bus.req_op_i))
                OP_READ: begin
                    if (upd_line_s[bus.req_sector_i] == SEC_INVALID) begin
                        upd_line_s[bus.req_sector_i] = SEC_CLEAN;
                    end else begin
                        upd_line_s[bus.req_sector_i] = line_r[hit_way_s][bus.req_sector_i];
                    end
                end
                OP_WRITE: upd_line_s[bus.req_sector_i] = SEC_DIRTY;
                OP_FLUSH: begin
                    if (upd_line_s[bus.req_sector_i] == SEC_DIRTY) begin
                        upd_line_s[bus.req_sector_i]   = SEC_CLEAN;
                        wb_gen_s                       = 1'b1;
                        wb_mask_nxt_s[bus.req_sector_i] = 1'b1;
                    end else begin
                        wb_gen_s = 1'b0;
                    end
                end
                OP_INVAL: begin
                    upd_line_s = '0;
                    cnt_dec_s  = 1'b1;
                end
                default: upd_line_s = line_r[hit_way_s];
            endcase
            rsp_way_nxt_s   = hit_way_s;
            rsp_state_nxt_s = upd_line_s[bus.req_sector_i];
        end else if (rw_s) begin
            // Miss: allocate the victim, writing back whatever of it is dirty.
            upd_way_s     = victim_way_s;
            upd_tag_s     = bus.req_tag_i;
            upd_line_s    = '0;
            upd_line_s[bus.req_sector_i] = (bus.req_op_i == OP_WRITE) ? SEC_DIRTY : SEC_CLEAN;
            wb_tag_nxt_s  = tag_r[victim_way_s];
            wb_mask_nxt_s = sec_match(line_r[victim_way_s], SEC_DIRTY);
            wb_gen_s      = |wb_mask_nxt_s;
            cnt_inc_s     = ~line_valid_s[victim_way_s];
            rsp_way_nxt_s   = victim_way_s;
            rsp_state_nxt_s = upd_line_s[bus.req_sector_i];
        end else begin
            upd_line_s = line_r[hit_way_s];
        end
    end

    // Tag/state array and valid-line count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_r[w]  <= '0;
                line_r[w] <= '0;
            end
            count_r <= '0;
        end else if (accept_s && (hit_s || rw_s)) begin
            tag_r[upd_way_s]  <= upd_tag_s;
            line_r[upd_way_s] <= upd_line_s;
            count_r <= count_r + (WAY_W+1)'(cnt_inc_s) - (WAY_W+1)'(cnt_dec_s);
        end
    end

    // Response and writeback payload registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_way_r   <= '0;
            rsp_state_r <= 2'd0;
            wb_tag_r    <= '0;
            wb_way_r    <= '0;
            wb_mask_r   <= '0;
        end else begin
            rsp_valid_r <= accept_s;
            if (accept_s) begin
                rsp_hit_r   <= hit_s;
                rsp_way_r   <= rsp_way_nxt_s;
                rsp_state_r <= rsp_state_nxt_s;
            end
            // Payload only loads from IDLE, so it stays put through WB_WAIT.
            if (accept_s && wb_gen_s) begin
                wb_tag_r  <= wb_tag_nxt_s;
                wb_way_r  <= upd_way_s;
                wb_mask_r <= wb_mask_nxt_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && wb_gen_s) begin
                    state_nxt_s = ST_WB_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB_WAIT: begin
                if (bus.wb_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WB_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    bank_htu_plru_tree_param #(.WAYS(WAYS)) u_plru (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .touch_valid_i (accept_s && rw_s),
        .touch_way_i   (touch_way_s),
        .victim_oh_o   (plru_oh_s)
    );

    bank_htu_set_entry_wb_chk #(.WAYS(WAYS)) u_chk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .check_i   (accept_s),
        .hit_vec_i (hit_vec_s)
    );

    assign bus.req_ready_o   = (state_r == ST_IDLE);
    assign bus.rsp_valid_o   = rsp_valid_r;
    assign bus.rsp_hit_o     = rsp_hit_r;
    assign bus.rsp_way_o     = rsp_way_r;
    assign bus.rsp_state_o   = rsp_state_r;
    assign bus.wb_valid_o    = (state_r == ST_WB_WAIT);
    assign bus.wb_tag_o      = wb_tag_r;
    assign bus.wb_way_o      = wb_way_r;
    assign bus.wb_mask_o     = wb_mask_r;
    assign bus.valid_count_o = count_r;

endmodule

// File: tb/tb_bank_htu_set_entry_wb.sv
// Self-checking bench for bank_htu_set_entry_wb (WAYS=8, SECTORS=2):
// directed steps followed by random traffic, checked against a behavioural
// set model (per-way tag/sector arrays and a halving-range PLRU tree).
module tb_bank_htu_set_entry_wb;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // model state
    int mtag [8];
    int mst  [8][2];
    bit mnode[7];
    int mcnt;
    // expected results of the last request
    bit e_hit, e_wb;
    int e_way, e_state, e_wbtag, e_wbway, e_wbmask;

    bank_htu_set_entry_wb_if #(.WAYS(8), .SECTORS(2), .TAG_W(22)) bus ();

    bank_htu_set_entry_wb #(.WAYS(8), .SECTORS(2), .TAG_W(22)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit mvalid(input int w);
        return (mst[w][0] != 0) || (mst[w][1] != 0);
    endfunction

    // Descend the tree: each node says which half of its range is older.
    function automatic int plru_pick();
        int lo = 0, size = 8, n = 0;
        while (size > 1) begin
            size = size / 2;
            if (mnode[n]) begin
                lo = lo + size;
                n  = 2 * n + 2;
            end else begin
                n  = 2 * n + 1;
            end
        end
        return lo;
    endfunction

    task automatic mtouch(input int w);
        int lo = 0, size = 8, n = 0;
        while (size > 1) begin
            size = size / 2;
            if (w < lo + size) begin
                mnode[n] = 1'b1;
                n = 2 * n + 1;
            end else begin
                mnode[n] = 1'b0;
                lo = lo + size;
                n = 2 * n + 2;
            end
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 8; w++) begin
            mtag[w] = 0; mst[w][0] = 0; mst[w][1] = 0;
        end
        for (int n = 0; n < 7; n++) mnode[n] = 1'b0;
        mcnt = 0;
    endtask

    task automatic model_access(input int op, input int tag, input int sec);
        int hw = -1, v = -1, dm = 0;
        e_wb = 0; e_wbtag = 0; e_wbway = 0; e_wbmask = 0;
        for (int w = 0; w < 8; w++) if (mvalid(w) && mtag[w] == tag) hw = w;
        if (hw >= 0) begin
            e_hit = 1; e_way = hw;
            case (op)
                0: begin if (mst[hw][sec] == 0) mst[hw][sec] = 1; mtouch(hw); end
                1: begin mst[hw][sec] = 2; mtouch(hw); end
                2: if (mst[hw][sec] == 2) begin
                       e_wb = 1; e_wbtag = tag; e_wbway = hw; e_wbmask = 1 << sec;
                       mst[hw][sec] = 1;
                   end
                default: begin mst[hw][0] = 0; mst[hw][1] = 0; mcnt--; end
            endcase
            e_state = mst[hw][sec];
        end else if (op < 2) begin
            for (int w = 7; w >= 0; w--) if (!mvalid(w)) v = w;
            if (v < 0) v = plru_pick();
            if (!mvalid(v)) mcnt++;
            for (int s = 0; s < 2; s++) if (mst[v][s] == 2) dm |= (1 << s);
            if (dm != 0) begin
                e_wb = 1; e_wbtag = mtag[v]; e_wbway = v; e_wbmask = dm;
            end
            mtag[v] = tag; mst[v][0] = 0; mst[v][1] = 0;
            mst[v][sec] = (op == 1) ? 2 : 1;
            mtouch(v);
            e_hit = 0; e_way = v; e_state = mst[v][sec];
        end else begin
            e_hit = 0; e_way = 0; e_state = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.req_valid_i = 1'b0; bus.wb_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_ready", bus.req_ready_o, 1);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_wb_valid", bus.wb_valid_o, 0);
        check("rst_wb_tag", bus.wb_tag_o, 0);
        check("rst_wb_mask", bus.wb_mask_o, 0);
        check("rst_count", bus.valid_count_o, 0);
    endtask

    // One request; stall = cycles of wb_ready low, negative = leave WB pending.
    task automatic do_req(input int op, input int tag, input int sec, input int stall);
        @(negedge clk);
        check("rsp_pulse_end", bus.rsp_valid_o, 0);
        bus.req_valid_i  = 1'b1;
        bus.req_op_i     = op[1:0];
        bus.req_tag_i    = tag[21:0];
        bus.req_sector_i = sec[0:0];
        check("req_ready", bus.req_ready_o, 1);
        @(posedge clk);
        model_access(op, tag, sec);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("rsp_valid", bus.rsp_valid_o, 1);
        check("rsp_hit", bus.rsp_hit_o, e_hit);
        check("rsp_way", bus.rsp_way_o, e_way);
        check("rsp_state", bus.rsp_state_o, e_state);
        check("valid_count", bus.valid_count_o, mcnt);
        check("wb_valid", bus.wb_valid_o, e_wb);
        if (e_wb) begin
            check("wb_tag", bus.wb_tag_o, e_wbtag);
            check("wb_way", bus.wb_way_o, e_wbway);
            check("wb_mask", bus.wb_mask_o, e_wbmask);
            if (stall < 0) return;
            for (int i = 0; i < stall; i++) begin
                bus.req_valid_i = 1'b1;
                bus.req_op_i    = 2'($urandom_range(0, 3));
                @(negedge clk);
                check("stall_ready", bus.req_ready_o, 0);
                check("stall_wb_valid", bus.wb_valid_o, 1);
                check("stall_wb_tag", bus.wb_tag_o, e_wbtag);
                check("stall_wb_way", bus.wb_way_o, e_wbway);
                check("stall_wb_mask", bus.wb_mask_o, e_wbmask);
                check("stall_count", bus.valid_count_o, mcnt);
            end
            bus.req_valid_i = 1'b0;
            bus.wb_ready_i  = 1'b1;
            @(negedge clk);
            bus.wb_ready_i  = 1'b0;
            check("post_wb_ready", bus.req_ready_o, 1);
            check("post_wb_valid", bus.wb_valid_o, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_op_i = 2'd0; bus.req_tag_i = 22'd0;
        bus.req_sector_i = 1'b0; bus.wb_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // first allocation, then fill and evict a clean line
        do_req(0, 'h100, 0, 0);
        for (int t = 'h101; t <= 'h107; t++) do_req(0, t, 0, 0);
        do_req(0, 'h108, 0, 0);

        // dirty sector 1 in way 0, fill, evict with back-pressure
        do_reset();
        do_req(1, 'h100, 1, 0);
        for (int t = 'h101; t <= 'h107; t++) do_req(0, t, 0, 0);
        do_req(0, 'h108, 0, 3);

        // write / flush / invalidate one line, then flush/inval misses
        do_req(1, 'h200, 0, 1);
        do_req(2, 'h200, 0, 0);
        do_req(2, 'h200, 0, 0);
        do_req(3, 'h200, 0, 0);
        do_req(2, 'h3ff, 1, 0);
        do_req(3, 'h3ff, 0, 0);

        // random traffic over a small tag pool to force hits and evictions
        for (int i = 0; i < 300; i++) begin
            do_req(int'($urandom_range(0, 3)), 'h300 + int'($urandom_range(0, 11)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        // reset while a writeback is pending
        do_reset();
        do_req(1, 'h400, 0, 0);
        do_req(2, 'h400, 0, -1);
        do_reset();
        do_req(0, 'h400, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
